commit_trace_queue: RTL and testbench
=====================================

Name: commit_trace_queue

Overview:
- Elastic buffer between the core's retirement trace port (CSR trace valid/iaddr/insn, hartid, regfile write data) and the co-simulation checker.
- The core cannot be back-pressured. The queue absorbs bursts when the checker is slow and hands entries over on a valid/ready handshake.
- On overflow it stops accepting, drains what it holds, then latches an error so the bench can fail with a clear reason instead of a spurious mismatch.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2
- XLEN, 64, width of pc and wdata
- HARTID_W, 8, width of hartid
- DROP_W, 16, width of the saturating drop counter

Ports:
- clock  input  1  sole clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  one instruction retired this cycle
- in_hartid  input  HARTID_W  retiring hart id
- in_pc  input  XLEN  retired pc
- in_inst  input  32  retired instruction word
- in_wdata  input  XLEN  regfile write data
- out_valid  output  1  head entry available
- out_ready  input  1  checker accepts head entry
- out_hartid / out_pc / out_inst / out_wdata  output  HARTID_W / XLEN / 32 / XLEN  head entry fields
- level  output  $clog2(DEPTH)+1  current occupancy
- high_water  output  $clog2(DEPTH)+1  maximum occupancy seen since reset
- overflow  output  1  sticky; set on the first dropped retirement
- drop_count  output  DROP_W  retirements dropped; saturates at all-ones
- error  output  1  high in HALT state

Behaviour:
- Reset values: all outputs 0; state RUN; read pointer, write pointer and count 0. Storage contents are don't-care.
- Storage: register array of {hartid, pc, inst, wdata}; read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Output path is first-word fall-through:
  - out_valid = (count != 0).
  - out_* are driven combinationally from the head slot.
  - An entry pushed in cycle N is presented at out_* in cycle N+1.
- pop = out_valid && out_ready. It advances the read pointer in every state, including DRAIN.
- push happens only when state==RUN && in_valid && (count<DEPTH || pop).
  - Full with a simultaneous pop: the push is accepted and count is unchanged.
- count' = count + push - pop. level = count.
- high_water' = max(high_water, count'). It is registered, so it reflects the post-update occupancy.
- State machine:
  - RUN: in_valid && count==DEPTH && !pop → drop the entry, set overflow, drop_count+1, go to DRAIN.
  - DRAIN: every in_valid is dropped and counted. When count'==0, go to HALT.
  - HALT: error=1. in_valid is still counted as drops. Pops cannot occur because the queue is empty. The block stays in HALT until reset.
- drop_count saturates at 2^DROP_W-1 and never wraps.
- out_* hold their value while out_valid && !out_ready.
- Checker rule: must not sample out_* when out_valid==0. Their values are undefined in that case.
- Reset asserted mid-operation: state returns to RUN immediately (asynchronous). Queued entries, overflow, error and high_water are all lost.
- in_valid during reset is ignored.
- The first rising edge after reset deasserts may accept a push.
- No X propagation from uninitialised storage onto out_valid, level, overflow, drop_count or error.

Test Plan:
- Single push: in_valid=1 for 1 cycle with pc=0x80000000, inst=0x00000013, out_ready=1 → out_valid=1 the next cycle with matching fields; level 1→0 after the pop; high_water=1.
- Burst with stall: out_ready=0, push 16 entries with pc=0x80000000+4k → level=16 with no overflow. Then out_ready=1 → 16 pops in order, pc ascending, level back to 0.
- Full plus simultaneous push/pop: fill to 16, then in_valid=1 and out_ready=1 in the same cycle → level stays 16, overflow=0, new entry emerges 16th after the popped one.
- Overflow: fill to 16 with out_ready=0, push 3 more → overflow=1, drop_count=3, state DRAIN. Set out_ready=1 → 16 original entries drain, then error=1; further in_valid increments drop_count.
- Saturation: with DROP_W=4, hold in_valid=1 for 20 cycles while in HALT → drop_count=15 and stays 15.
- Async reset mid-burst: level=9 and overflow=1, pulse reset between clock edges → all outputs read 0 before the next edge; a push on the following edge gives level=1.

Source files
------------

// File: rtl/commit_trace_queue.sv
// Elastic FIFO between the core's retirement trace port and the co-simulation checker.
// On overflow it stops accepting, drains what it holds, then halts with error raised.
module commit_trace_queue #(
   parameter int DEPTH    = 16,
   parameter int XLEN     = 64,
   parameter int HARTID_W = 8,
   parameter int DROP_W   = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [HARTID_W-1:0]      in_hartid,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [31:0]              in_inst,
   input  logic [XLEN-1:0]          in_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [HARTID_W-1:0]      out_hartid,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_inst,
   output logic [XLEN-1:0]          out_wdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic [$clog2(DEPTH):0]   high_water,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_count,
   output logic                     error
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [HARTID_W-1:0] hartid_mem [DEPTH];
   logic [XLEN-1:0]     pc_mem     [DEPTH];
   logic [31:0]         inst_mem   [DEPTH];
   logic [XLEN-1:0]     wdata_mem  [DEPTH];

   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_next;
   logic          push, pop, drop;

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = (state == ST_RUN) && in_valid && ((count < FULL_COUNT) || pop);
   assign drop      = in_valid && !push;
   assign level     = count;
   assign error     = (state == ST_HALT);

   // Head fields are zeroed when empty so uninitialised storage never leaks out.
   assign out_hartid = out_valid ? hartid_mem[rd_ptr] : '0;
   assign out_pc     = out_valid ? pc_mem[rd_ptr]     : '0;
   assign out_inst   = out_valid ? inst_mem[rd_ptr]   : '0;
   assign out_wdata  = out_valid ? wdata_mem[rd_ptr]  : '0;

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:   if (drop) state_next = ST_DRAIN;
         ST_DRAIN: if (count_next == '0) state_next = ST_HALT;
         ST_HALT:  state_next = ST_HALT;
         default:  state_next = ST_RUN;
      endcase
   end

   // Storage carries no reset; only pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         hartid_mem[wr_ptr] <= in_hartid;
         pc_mem[wr_ptr]     <= in_pc;
         inst_mem[wr_ptr]   <= in_inst;
         wdata_mem[wr_ptr]  <= in_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_RUN;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         high_water <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (count_next > high_water) high_water <= count_next;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed and randomized bench for commit_trace_queue, checked against a queue-based
// reference model of the retirement trace buffer.
module tb_commit_trace_queue;

   localparam int DEPTH    = 16;
   localparam int XLEN     = 64;
   localparam int HARTID_W = 8;
   localparam int DROP_W   = 4;
   localparam int DROP_MAX = 15;

   typedef struct packed {
      logic [HARTID_W-1:0] h;
      logic [XLEN-1:0]     pc;
      logic [31:0]         inst;
      logic [XLEN-1:0]     wd;
   } entry_t;

   logic                  clock, reset, in_valid, out_ready;
   logic [HARTID_W-1:0]   in_hartid;
   logic [XLEN-1:0]       in_pc, in_wdata;
   logic [31:0]           in_inst;
   logic                  out_valid, overflow, error;
   logic [HARTID_W-1:0]   out_hartid;
   logic [XLEN-1:0]       out_pc, out_wdata;
   logic [31:0]           out_inst;
   logic [$clog2(DEPTH):0] level, high_water;
   logic [DROP_W-1:0]     drop_count;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: contents, mode (0 run, 1 drain, 2 halt), sticky flags.
   entry_t q[$];
   int     mode, model_hw, model_drops;
   bit     model_ovf;

   commit_trace_queue #(
      .DEPTH(DEPTH), .XLEN(XLEN), .HARTID_W(HARTID_W), .DROP_W(DROP_W)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_hartid(in_hartid), .in_pc(in_pc),
      .in_inst(in_inst), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hartid(out_hartid), .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
      .level(level), .high_water(high_water), .overflow(overflow),
      .drop_count(drop_count), .error(error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic entry_t randEntry();
      entry_t e;
      e.h    = HARTID_W'($urandom);
      e.pc   = {$urandom, $urandom};
      e.inst = $urandom;
      e.wd   = {$urandom, $urandom};
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      cmp("out_valid", 64'(out_valid), 64'(q.size() != 0));
      cmp("level", 64'(level), 64'(q.size()));
      cmp("high_water", 64'(high_water), 64'(model_hw));
      cmp("overflow", 64'(overflow), 64'(model_ovf));
      cmp("drop_count", 64'(drop_count), 64'(model_drops));
      cmp("error", 64'(error), 64'(mode == 2));
      if (q.size() != 0) begin
         cmp("out_hartid", 64'(out_hartid), 64'(q[0].h));
         cmp("out_pc", out_pc, q[0].pc);
         cmp("out_inst", 64'(out_inst), 64'(q[0].inst));
         cmp("out_wdata", out_wdata, q[0].wd);
      end
   endtask

   task automatic modelClear();
      q.delete();
      mode        = 0;
      model_hw    = 0;
      model_drops = 0;
      model_ovf   = 1'b0;
   endtask

   // Drives one cycle of inputs, advances the model, then checks after the edge.
   task automatic applyStimulus(input bit v, input bit r, input entry_t e);
      bit pop, push;
      int old_mode;
      in_valid  = v;
      out_ready = r;
      in_hartid = e.h;
      in_pc     = e.pc;
      in_inst   = e.inst;
      in_wdata  = e.wd;
      old_mode  = mode;
      pop  = (q.size() != 0) && r;
      push = (mode == 0) && v && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (v && !push) begin
         model_ovf = 1'b1;
         if (model_drops < DROP_MAX) model_drops++;
         if (old_mode == 0) mode = 1;
      end
      if (old_mode == 1 && q.size() == 0) mode = 2;
      if (q.size() > model_hw) model_hw = q.size();
      @(posedge clock);
      @(negedge clock);
      checkOutput();
   endtask

   // Pulses reset inside the low clock phase and checks outputs before the next edge.
   task automatic doReset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      modelClear();
      #1;
      checkOutput();
      cmp("rst_out_pc", out_pc, 64'd0);
      cmp("rst_out_wdata", out_wdata, 64'd0);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      entry_t e;
      modelClear();
      reset     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      e = randEntry();
      in_hartid = e.h;
      in_pc     = e.pc;
      in_inst   = e.inst;
      in_wdata  = e.wd;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput();
      reset    = 1'b0;
      in_valid = 1'b0;

      e = randEntry();
      e.pc   = 64'h8000_0000;
      e.inst = 32'h0000_0013;
      applyStimulus(1'b1, 1'b1, e);
      cmp("single_pc", out_pc, 64'h8000_0000);
      applyStimulus(1'b0, 1'b1, randEntry());
      cmp("single_level", 64'(level), 64'd0);
      cmp("single_hw", 64'(high_water), 64'd1);

      for (int k = 0; k < 16; k++) begin
         e = randEntry();
         e.pc = 64'h8000_0000 + 64'(4 * k);
         applyStimulus(1'b1, 1'b0, e);
      end
      cmp("burst_level", 64'(level), 64'd16);
      cmp("burst_ovf", 64'(overflow), 64'd0);
      for (int k = 0; k < 16; k++) begin
         cmp("burst_order_pc", out_pc, 64'h8000_0000 + 64'(4 * k));
         applyStimulus(1'b0, 1'b1, randEntry());
      end
      cmp("burst_empty", 64'(level), 64'd0);

      doReset();
      repeat (300) applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), randEntry());

      doReset();
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, randEntry());
      applyStimulus(1'b1, 1'b1, randEntry());
      cmp("full_pp_level", 64'(level), 64'd16);
      cmp("full_pp_ovf", 64'(overflow), 64'd0);
      for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, randEntry());

      doReset();
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, randEntry());
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, randEntry());
      cmp("ovf_flag", 64'(overflow), 64'd1);
      cmp("ovf_drops", 64'(drop_count), 64'd3);
      cmp("ovf_level", 64'(level), 64'd16);
      for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, randEntry());
      cmp("halt_error", 64'(error), 64'd1);
      repeat (20) applyStimulus(1'b1, 1'b1, randEntry());
      cmp("sat_drops", 64'(drop_count), 64'd15);

      doReset();
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, randEntry());
      applyStimulus(1'b1, 1'b0, randEntry());
      for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, randEntry());
      cmp("mid_level", 64'(level), 64'd9);
      cmp("mid_ovf", 64'(overflow), 64'd1);
      doReset();
      applyStimulus(1'b1, 1'b0, randEntry());
      cmp("post_rst_level", 64'(level), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
